// File: rtl/branch_predict_fetch.sv
// Fetch-side PC generator with a 2-bit bimodal branch history table.
// Predicts B-type branches at fetch, trains the table from the execute-stage
// resolution, and redirects/flushes on a mispredicted branch or any jump.
module branch_predict_fetch #(
  parameter int              XLEN        = 32,
  parameter int              BHT_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_branch,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_jump,
  input  logic [XLEN-1:0] ex_jump_target,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispred_count
);

  localparam int              IDX         = $clog2(BHT_ENTRIES);
  localparam logic [6:0]      OP_BRANCH   = 7'b1100011;
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
  localparam logic [1:0]      WEAK_NT     = 2'b01;

  logic [1:0]             bht [BHT_ENTRIES];
  logic [IDX-1:0]         fetch_idx;
  logic [IDX-1:0]         ex_idx;
  logic                   is_branch_op;
  logic signed [XLEN-1:0] b_imm;
  logic [XLEN-1:0]        pred_target;
  logic [XLEN-1:0]        redirect_pc;
  logic                   mispredict;
  logic                   train;
  logic                   unused_bits;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11)
      nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00)
      nxt = ctr - 2'b01;
    return nxt;
  endfunction

  assign fetch_idx    = pc[IDX+1:2];
  assign ex_idx       = ex_pc[IDX+1:2];
  assign is_branch_op = (fetch_instr[6:0] == OP_BRANCH);

  // Only the immediate, opcode and alignment bits matter here; the rest is tied off.
  assign unused_bits = ^{fetch_instr[24:12], pc[1:0], ex_pc[1:0]};

  // Prediction and redirect decode (combinational, same cycle as fetch / EX).
  always_comb begin
    b_imm       = {{(XLEN-12){fetch_instr[31]}}, fetch_instr[7], fetch_instr[30:25],
                   fetch_instr[11:8], 1'b0};
    pred_target = pc + $unsigned(b_imm);
    pred_taken  = is_branch_op & bht[fetch_idx][1];
    mispredict  = ex_valid & ((ex_is_branch & (ex_branch != ex_pred_taken)) | ex_jump);
    train       = ex_valid & ex_is_branch;
    // Reset already discards every pipeline register, so no flush is raised during it.
    flush       = mispredict & ~reset;
    if (ex_jump)
      redirect_pc = ex_jump_target;
    else if (ex_branch)
      redirect_pc = ex_target;
    else
      redirect_pc = ex_pc + INSTR_BYTES;
  end

  // Fetch PC: reset > mispredict redirect > stall hold > predicted/sequential.
  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (mispredict)
      pc <= redirect_pc;
    else if (!stall)
      pc <= pred_taken ? pred_target : pc + INSTR_BYTES;
  end

  // BHT training from EX; ignores stall. A same-index fetch read sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= WEAK_NT;
    end else if (train) begin
      bht[ex_idx] <= sat_update(bht[ex_idx], ex_branch);
    end
  end

  // Resolved-branch and redirect statistics, both free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count  <= '0;
      mispred_count <= '0;
    end else begin
      if (train)
        branch_count <= branch_count + 32'd1;
      if (mispredict)
        mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Testbench for branch_predict_fetch: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the fetch/predict rules.
module tb_branch_predict_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam longint      MOD = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, ex_valid, ex_is_branch, ex_branch, ex_pred_taken, ex_jump;
  logic [31:0] fetch_instr, ex_pc, ex_target, ex_jump_target;
  logic [31:0] pc, branch_count, mispred_count;
  logic        pred_taken, flush;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  longint m_pc;
  int     m_bht [64];
  longint m_branches, m_mispred;

  branch_predict_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_instr(fetch_instr),
    .pc(pc), .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_branch(ex_branch), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_jump(ex_jump), .ex_jump_target(ex_jump_target),
    .flush(flush), .branch_count(branch_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Signed B-type immediate, assembled from its scattered fields arithmetically.
  function automatic longint b_imm_of(input logic [31:0] i);
    longint v;
    v = longint'(i[11:8]) * 2 + longint'(i[30:25]) * 32 + longint'(i[7]) * 2048
        + longint'(i[31]) * 4096;
    if (i[31]) v = v - 8192;
    return v;
  endfunction

  // One clock: drive at the falling edge, check combinational outputs, advance
  // the model, then check registered outputs at the next falling edge.
  task automatic step(input logic rst_i, input logic stall_i, input logic [31:0] instr,
                      input logic ev, input logic eb, input logic ebr, input logic ep,
                      input logic [31:0] epc, input logic [31:0] et,
                      input logic ej, input logic [31:0] ejt);
    int     fi, ei;
    bit     exp_pred, exp_mis;
    longint npc;
    reset = rst_i; stall = stall_i; fetch_instr = instr;
    ex_valid = ev; ex_is_branch = eb; ex_branch = ebr; ex_pred_taken = ep;
    ex_pc = epc; ex_target = et; ex_jump = ej; ex_jump_target = ejt;
    #1;
    fi       = int'((m_pc / 4) % 64);
    exp_pred = (instr[6:0] == 7'h63) && (m_bht[fi] >= 2);
    exp_mis  = ev && ((eb && (ebr != ep)) || ej);
    check_val("pred_taken", {31'b0, pred_taken}, {31'b0, exp_pred});
    check_val("flush", {31'b0, flush}, {31'b0, exp_mis && !rst_i});
    if (rst_i) begin
      m_pc = 0;
      foreach (m_bht[k]) m_bht[k] = 1;
      m_branches = 0;
      m_mispred  = 0;
    end else begin
      if (exp_mis)
        npc = ej ? longint'(ejt) : (ebr ? longint'(et) : longint'(epc) + 4);
      else if (stall_i)
        npc = m_pc;
      else if (exp_pred)
        npc = m_pc + b_imm_of(instr);
      else
        npc = m_pc + 4;
      m_pc = ((npc % MOD) + MOD) % MOD;
      if (ev && eb) begin
        ei = int'((longint'(epc) / 4) % 64);
        m_bht[ei] = ebr ? ((m_bht[ei] < 3) ? m_bht[ei] + 1 : 3)
                        : ((m_bht[ei] > 0) ? m_bht[ei] - 1 : 0);
        m_branches = (m_branches + 1) % MOD;
      end
      if (exp_mis) m_mispred = (m_mispred + 1) % MOD;
    end
    @(negedge clk);
    check_val("pc", pc, 32'(m_pc));
    check_val("branch_count", branch_count, 32'(m_branches));
    check_val("mispred_count", mispred_count, 32'(m_mispred));
  endtask

  task automatic idle(input logic stall_i, input logic [31:0] instr);
    step(1'b0, stall_i, instr, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic jump_to(input logic stall_i, input logic [31:0] tgt);
    step(1'b0, stall_i, NOP, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, tgt);
  endtask

  initial begin
    logic [31:0] beq;
    logic [31:0] r, instr, epc;
    bit          ebr;
    m_pc = 0; m_branches = 0; m_mispred = 0;
    foreach (m_bht[k]) m_bht[k] = 1;
    beq = 32'h0200_0063;  // BEQ x0,x0,+0x20
    @(negedge clk);

    // Reset, then sequential fetch of non-branches.
    step(1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("reset_pc", pc, 32'h0);
    check_val("reset_mispred", mispred_count, 32'h0);
    for (int i = 0; i < 4; i++) idle(1'b0, NOP);
    check_val("seq_pc", pc, 32'h10);

    // BEQ at 0x10 predicted not-taken, resolves taken: redirect to 0x30.
    idle(1'b0, beq);
    step(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h30, 1'b0, 32'h0);
    check_val("redirect_pc", pc, 32'h30);
    check_val("redirect_mispred", mispred_count, 32'd1);
    check_val("redirect_branches", branch_count, 32'd1);

    // Refetch the BEQ: now predicted taken straight to 0x30, and correctly resolved.
    jump_to(1'b0, 32'h10);
    idle(1'b0, beq);
    check_val("pred_pc", pc, 32'h30);
    step(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h30, 1'b0, 32'h0);
    step(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h30, 1'b0, 32'h0);
    jump_to(1'b0, 32'h10);
    idle(1'b0, beq);

    // Mispredict overrides stall; stall alone holds.
    jump_to(1'b1, 32'h200);
    check_val("stall_jump_pc", pc, 32'h200);
    idle(1'b1, NOP);
    check_val("stall_hold_pc", pc, 32'h200);

    // PC wraps at the top of the address space.
    jump_to(1'b0, 32'hFFFF_FFFC);
    idle(1'b0, NOP);
    check_val("wrap_pc", pc, 32'h0);

    // Reset concurrent with a mispredicting branch.
    step(1'b1, 1'b0, beq, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h30, 1'b0, 32'h0);
    check_val("rst_mis_pc", pc, 32'h0);
    check_val("rst_mis_branches", branch_count, 32'h0);
    jump_to(1'b0, 32'h10);
    idle(1'b0, beq);  // table back to weak not-taken: predicted 0

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      instr = $urandom;
      if (r[0]) instr[6:0] = 7'h63;
      epc = (r[3:2] != 2'b00) ? 32'(m_pc) - 32'(4 * (r[6:4] % 3)) : ($urandom & 32'hFFFF_FFFC);
      ebr = r[7];
      step(r[15:8] == 8'd0, r[17:16] == 2'b00, instr,
           r[19:18] != 2'b00, r[20], ebr, (r[22:21] == 2'b00) ? ~ebr : ebr,
           epc, $urandom & 32'hFFFF_FFFC, r[25:23] == 3'b000,
           $urandom & 32'h0000_FFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
